lpddr2_port_arbiter: RTL and testbench
======================================

Name: lpddr2_port_arbiter

Overview:
Shares one LPDDR2 multiport-controller Avalon-MM port between two masters: the HDMI TX frame reader (read-only, M0) and the frame loader/capture writer (write-only, M1). It issues single-beat bursts (burstcount fixed at 1, applied outside this block), with M0 given priority. A starvation guard lets M1 through after a bounded run of M0 reads, and an outstanding-read limit keeps the read FIFO from overflowing.

Parameters:
ADDR_W, 27, Avalon word address width
DATA_W, 32, data width
MAX_RD_RUN, 16, max consecutive M0 accepts while M1 is pending before M1 is forced
MAX_OUTSTANDING, 8, max reads accepted but not yet returned

Ports:
iCLK  in  1  port clock (same as the controller mp_cmd/rfifo/wfifo clock)
iRST_n  in  1  synchronous active-low reset
local_init_done  in  1  controller ready; no grants while low
m0_read  in  1  M0 read request
m0_address  in  ADDR_W  M0 address
m0_waitrequest_n  out  1  M0 accept qualifier
m0_readdatavalid  out  1  return data valid
m0_readdata  out  DATA_W  return data
m1_write  in  1  M1 write request
m1_address  in  ADDR_W  M1 address
m1_writedata  in  DATA_W  M1 data
m1_waitrequest_n  out  1  M1 accept qualifier
avl_ready  in  1  controller waitrequest_n
avl_burstbegin  out  1  first cycle of each command
avl_addr  out  ADDR_W  command address
avl_wdata  out  DATA_W  write data
avl_read_req  out  1  read command
avl_write_req  out  1  write command
avl_rdata_valid  in  1  read data valid
avl_rdata  in  DATA_W  read data
outstanding  out  $clog2(MAX_OUTSTANDING+1)  reads in flight
rd_underflow_err  out  1  sticky: rdata_valid seen with outstanding==0

Behaviour:
- Reset (synchronous, iRST_n low at a posedge, including mid-transfer): grant=NONE, rd_run=0, outstanding=0, rd_underflow_err=0, first=1. All req, burstbegin and waitrequest_n outputs are 0.
- Grant register g is one of NONE, RD, WR.
- Command mux, combinational from g:
  - g=RD: avl_read_req=m0_read, avl_addr=m0_address.
  - g=WR: avl_write_req=m1_write, avl_addr=m1_address, avl_wdata=m1_writedata.
  - g=NONE: both req=0, addr/wdata=0.
- m0_waitrequest_n = avl_ready & (g==RD). m1_waitrequest_n = avl_ready & (g==WR).
- Accept = granted req high & avl_ready high at a posedge.
- Re-arbitration happens at a posedge when g==NONE, or when the granted master accepts, or when the granted master's request is low.
  - Otherwise g holds. A held, unaccepted request always keeps its grant.
- Arbitration inputs:
  - rdc = m0_read & (outstanding < MAX_OUTSTANDING, counting an accept this cycle), gated by local_init_done.
  - wrc = m1_write & local_init_done.
- Arbitration result:
  - Both candidates: WR if rd_run >= MAX_RD_RUN, else RD.
  - One candidate: that one.
  - Neither: NONE.
- Latency: request seen at cycle N, command presented at N+1. Back-to-back accepts from the same master have no bubble.
- rd_run:
  - +1 (saturating) on each M0 accept while m1_write=1.
  - Cleared on each M1 accept, or when m1_write=0.
- avl_burstbegin = (avl_read_req | avl_write_req) & first.
  - first clears after a cycle with a presented command that is not accepted.
  - first sets on accept or on grant change.
- Outstanding counter:
  - +1 on M0 accept; -1 on avl_rdata_valid; both in the same cycle leave it unchanged.
  - Never exceeds MAX_OUTSTANDING.
  - avl_rdata_valid with outstanding==0 sets rd_underflow_err and the count stays 0.
- m0_readdatavalid/m0_readdata = avl_rdata_valid/avl_rdata passed through combinationally, in order.
- local_init_done dropping mid-grant: the current held command still completes; no new grants are issued.

Test Plan:
- Reset, then local_init_done=1, m0_read held, avl_ready=1 -> avl_read_req rises 1 cycle later, with burstbegin on every accepted beat. outstanding climbs to 8 and read_req drops until rdata_valid returns.
- m0_read and m1_write both held, avl_ready=1, rdata returned with 2-cycle latency -> exactly 16 reads, then 1 write, then 16 reads, repeating; m1_waitrequest_n is never starved.
- m1_write held, avl_ready low for 5 cycles -> g stays WR, avl_write_req=1 throughout, burstbegin on the first cycle only, accept on the 6th cycle. m0_read arriving mid-stall does not preempt.
- Accept and rdata_valid in the same cycle at outstanding=3 -> stays 3. rdata_valid at outstanding=0 -> rd_underflow_err=1 and sticky.
- iRST_n pulsed low while g=RD with 4 reads outstanding -> next cycle g=NONE, outstanding=0, all req=0, err=0.
- local_init_done=0 with both masters requesting -> no req asserted. Raising it -> RD granted first.

Source files
------------

// File: rtl/lpddr2_port_arbiter.sv
// Two-master arbiter for one LPDDR2 multiport-controller Avalon-MM port.
// M0 (HDMI reader) has priority; M1 (loader writer) is guaranteed a slot after a bounded read run.
module lpddr2_port_arbiter #(
   parameter int ADDR_W          = 27,
   parameter int DATA_W          = 32,
   parameter int MAX_RD_RUN      = 16,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                                   iCLK,
   input  logic                                   iRST_n,
   input  logic                                   local_init_done,
   input  logic                                   m0_read,
   input  logic [ADDR_W-1:0]                      m0_address,
   output logic                                   m0_waitrequest_n,
   output logic                                   m0_readdatavalid,
   output logic [DATA_W-1:0]                      m0_readdata,
   input  logic                                   m1_write,
   input  logic [ADDR_W-1:0]                      m1_address,
   input  logic [DATA_W-1:0]                      m1_writedata,
   output logic                                   m1_waitrequest_n,
   input  logic                                   avl_ready,
   output logic                                   avl_burstbegin,
   output logic [ADDR_W-1:0]                      avl_addr,
   output logic [DATA_W-1:0]                      avl_wdata,
   output logic                                   avl_read_req,
   output logic                                   avl_write_req,
   input  logic                                   avl_rdata_valid,
   input  logic [DATA_W-1:0]                      avl_rdata,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
   output logic                                   rd_underflow_err
);

   localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
   localparam int OW1 = OW + 1;
   localparam int RW  = $clog2(MAX_RD_RUN + 1);
   localparam logic [OW:0]   OS_LIMIT  = OW1'(MAX_OUTSTANDING);
   localparam logic [RW-1:0] RUN_LIMIT = RW'(MAX_RD_RUN);

   typedef enum logic [1:0] {G_NONE, G_RD, G_WR} grant_t;

   grant_t        g, g_nxt;
   logic [RW-1:0] rd_run, rd_run_nxt;
   logic          first;
   logic          acc_rd, acc_wr, g_req, rearb, rdc, wrc;
   logic [OW:0]   os_acc;

   always_comb begin
      avl_read_req  = 1'b0;
      avl_write_req = 1'b0;
      avl_addr      = '0;
      avl_wdata     = '0;
      case (g)
         G_RD: begin
            avl_read_req = m0_read;
            avl_addr     = m0_address;
         end
         G_WR: begin
            avl_write_req = m1_write;
            avl_addr      = m1_address;
            avl_wdata     = m1_writedata;
         end
         default: ;
      endcase
   end

   assign m0_waitrequest_n = avl_ready & (g == G_RD);
   assign m1_waitrequest_n = avl_ready & (g == G_WR);
   assign m0_readdatavalid = avl_rdata_valid;
   assign m0_readdata      = avl_rdata;

   assign g_req          = avl_read_req | avl_write_req;
   assign avl_burstbegin = g_req & first;
   assign acc_rd         = avl_read_req & avl_ready;
   assign acc_wr         = avl_write_req & avl_ready;
   assign rearb          = (g == G_NONE) | acc_rd | acc_wr | ~g_req;

   assign os_acc = {1'b0, outstanding} + OW1'(acc_rd);
   assign rdc    = m0_read & local_init_done & (os_acc < OS_LIMIT);
   assign wrc    = m1_write & local_init_done;

   // Arbitration sees the run count including this cycle's accept, so exactly
   // MAX_RD_RUN reads pass before a pending write is forced through.
   always_comb begin
      rd_run_nxt = rd_run;
      if (!m1_write || acc_wr)
         rd_run_nxt = '0;
      else if (acc_rd && rd_run != RUN_LIMIT)
         rd_run_nxt = rd_run + 1'b1;
   end

   always_comb begin
      g_nxt = g;
      if (rearb) begin
         if (rdc && wrc)
            g_nxt = (rd_run_nxt >= RUN_LIMIT) ? G_WR : G_RD;
         else if (rdc)
            g_nxt = G_RD;
         else if (wrc)
            g_nxt = G_WR;
         else
            g_nxt = G_NONE;
      end
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_n) begin
         g                <= G_NONE;
         rd_run           <= '0;
         first            <= 1'b1;
         outstanding      <= '0;
         rd_underflow_err <= 1'b0;
      end else begin
         g      <= g_nxt;
         rd_run <= rd_run_nxt;
         if (acc_rd || acc_wr || (g_nxt != g))
            first <= 1'b1;
         else if (g_req)
            first <= 1'b0;
         case ({acc_rd, avl_rdata_valid})
            2'b10: outstanding <= outstanding + 1'b1;
            2'b01: begin
               if (outstanding == '0)
                  rd_underflow_err <= 1'b1;
               else
                  outstanding <= outstanding - 1'b1;
            end
            2'b11: begin
               if (outstanding == '0)
                  rd_underflow_err <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lpddr2_port_arbiter.sv
// Bench for lpddr2_port_arbiter: per-cycle vector table, then scoreboarded
// read traffic against an in-order memory responder.
module tb_lpddr2_port_arbiter;

   localparam int ADDR_W = 27;
   localparam int DATA_W = 32;
   localparam int RUN    = 16;
   localparam int MAXOS  = 8;
   localparam int LAT    = 2;
   localparam int NV     = 23;

   logic              iCLK = 1'b0;
   logic              iRST_n, local_init_done;
   logic              m0_read, m0_waitrequest_n, m0_readdatavalid;
   logic [ADDR_W-1:0] m0_address;
   logic [DATA_W-1:0] m0_readdata;
   logic              m1_write, m1_waitrequest_n;
   logic [ADDR_W-1:0] m1_address;
   logic [DATA_W-1:0] m1_writedata;
   logic              avl_ready, avl_burstbegin, avl_read_req, avl_write_req, avl_rdata_valid;
   logic [ADDR_W-1:0] avl_addr;
   logic [DATA_W-1:0] avl_wdata, avl_rdata;
   logic [3:0]        outstanding;
   logic              rd_underflow_err;

   always #5 iCLK = ~iCLK;

   lpddr2_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RD_RUN(RUN), .MAX_OUTSTANDING(MAXOS)
   ) dut (
      .iCLK(iCLK), .iRST_n(iRST_n), .local_init_done(local_init_done),
      .m0_read(m0_read), .m0_address(m0_address), .m0_waitrequest_n(m0_waitrequest_n),
      .m0_readdatavalid(m0_readdatavalid), .m0_readdata(m0_readdata),
      .m1_write(m1_write), .m1_address(m1_address), .m1_writedata(m1_writedata),
      .m1_waitrequest_n(m1_waitrequest_n), .avl_ready(avl_ready),
      .avl_burstbegin(avl_burstbegin), .avl_addr(avl_addr), .avl_wdata(avl_wdata),
      .avl_read_req(avl_read_req), .avl_write_req(avl_write_req),
      .avl_rdata_valid(avl_rdata_valid), .avl_rdata(avl_rdata),
      .outstanding(outstanding), .rd_underflow_err(rd_underflow_err)
   );

   // in = {init, m0_read, m1_write, avl_ready, rdata_valid}
   // ex = {read_req, write_req, burstbegin, m0_waitrequest_n, m1_waitrequest_n}
   typedef struct {
      bit [4:0]    in;
      bit [4:0]    ex;
      int unsigned os;
      bit          err;
   } vec_t;

   typedef struct {
      int unsigned       due;
      logic [DATA_W-1:0] data;
   } ret_t;

   vec_t              tbl [NV];
   ret_t              ret_q[$];
   logic [DATA_W-1:0] exp_q[$];
   int                checks = 0;
   int                errors = 0;
   bit                sb_en = 1'b0;
   bit                hold = 1'b0;
   int unsigned       cyc_n = 0;
   bit                last_rd_acc, last_wr_acc, last_bb;

   function automatic logic [DATA_W-1:0] mem_f(input logic [ADDR_W-1:0] a);
      return {a[15:0] ^ 16'h5A3C, a[15:0]};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One clock cycle: observe accepts/returns, cross the edge, then update
   // master addresses and the memory responder for the next cycle.
   task automatic step();
      ret_t r;
      #1;
      last_rd_acc = avl_read_req && avl_ready;
      last_wr_acc = avl_write_req && avl_ready;
      last_bb     = avl_burstbegin;
      if (sb_en && last_rd_acc) begin
         exp_q.push_back(mem_f(m0_address));
         r.due  = cyc_n + LAT;
         r.data = mem_f(avl_addr);
         ret_q.push_back(r);
      end
      if (last_wr_acc) begin
         chk("wr_addr", 64'(avl_addr), 64'(m1_address));
         chk("wr_data", 64'(avl_wdata), 64'(m1_writedata));
      end
      if (sb_en && m0_readdatavalid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_rdv: got data %0h expected none", m0_readdata);
         end else begin
            chk("rdata", 64'(m0_readdata), 64'(exp_q.pop_front()));
         end
      end
      @(posedge iCLK);
      @(negedge iCLK);
      cyc_n++;
      if (last_rd_acc) m0_address = m0_address + 1'b1;
      if (last_wr_acc) begin
         m1_address   = m1_address + 1'b1;
         m1_writedata = $urandom;
      end
      if (sb_en) begin
         avl_rdata_valid = 1'b0;
         avl_rdata       = '0;
         if (!hold && ret_q.size() > 0 && ret_q[0].due <= cyc_n) begin
            r               = ret_q.pop_front();
            avl_rdata_valid = 1'b1;
            avl_rdata       = r.data;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int nacc, rr, nw;
      bit prev_w;

      tbl[0]  = '{5'b01110, 5'b00000, 0, 1'b0};
      tbl[1]  = '{5'b01110, 5'b00000, 0, 1'b0};
      tbl[2]  = '{5'b11100, 5'b00000, 0, 1'b0};
      tbl[3]  = '{5'b11100, 5'b10100, 0, 1'b0};
      tbl[4]  = '{5'b11110, 5'b10010, 0, 1'b0};
      tbl[5]  = '{5'b10100, 5'b00000, 1, 1'b0};
      tbl[6]  = '{5'b10100, 5'b01100, 1, 1'b0};
      tbl[7]  = '{5'b11100, 5'b01000, 1, 1'b0};
      tbl[8]  = '{5'b11100, 5'b01000, 1, 1'b0};
      tbl[9]  = '{5'b11100, 5'b01000, 1, 1'b0};
      tbl[10] = '{5'b11100, 5'b01000, 1, 1'b0};
      tbl[11] = '{5'b11110, 5'b01001, 1, 1'b0};
      tbl[12] = '{5'b11010, 5'b10110, 1, 1'b0};
      tbl[13] = '{5'b11010, 5'b10110, 2, 1'b0};
      tbl[14] = '{5'b11011, 5'b10110, 3, 1'b0};
      tbl[15] = '{5'b10010, 5'b00010, 3, 1'b0};
      tbl[16] = '{5'b10011, 5'b00000, 3, 1'b0};
      tbl[17] = '{5'b10011, 5'b00000, 2, 1'b0};
      tbl[18] = '{5'b10011, 5'b00000, 1, 1'b0};
      tbl[19] = '{5'b10011, 5'b00000, 0, 1'b0};
      tbl[20] = '{5'b10010, 5'b00000, 0, 1'b1};
      tbl[21] = '{5'b10011, 5'b00000, 0, 1'b1};
      tbl[22] = '{5'b10010, 5'b00000, 0, 1'b1};

      iRST_n = 1'b0; local_init_done = 1'b0;
      m0_read = 1'b0; m1_write = 1'b0; avl_ready = 1'b0;
      avl_rdata_valid = 1'b0; avl_rdata = '0;
      m0_address = 27'h100; m1_address = 27'h8000; m1_writedata = 32'h1234_5678;
      @(negedge iCLK);
      @(negedge iCLK);
      iRST_n = 1'b1;

      // Gating, priority, write stall, same-cycle accept/return, underflow
      for (int i = 0; i < NV; i++) begin
         local_init_done = tbl[i].in[4];
         m0_read         = tbl[i].in[3];
         m1_write        = tbl[i].in[2];
         avl_ready       = tbl[i].in[1];
         avl_rdata_valid = tbl[i].in[0];
         avl_rdata       = 32'hC0DE_0000 + 32'(i);
         #1;
         chk($sformatf("v%0d_read_req", i),  64'(avl_read_req),     64'(tbl[i].ex[4]));
         chk($sformatf("v%0d_write_req", i), 64'(avl_write_req),    64'(tbl[i].ex[3]));
         chk($sformatf("v%0d_burstbegin", i), 64'(avl_burstbegin),  64'(tbl[i].ex[2]));
         chk($sformatf("v%0d_m0_wrn", i),    64'(m0_waitrequest_n), 64'(tbl[i].ex[1]));
         chk($sformatf("v%0d_m1_wrn", i),    64'(m1_waitrequest_n), 64'(tbl[i].ex[0]));
         chk($sformatf("v%0d_outstanding", i), 64'(outstanding),    64'(tbl[i].os));
         chk($sformatf("v%0d_underflow", i), 64'(rd_underflow_err), 64'(tbl[i].err));
         chk($sformatf("v%0d_rdv", i),       64'(m0_readdatavalid), 64'(tbl[i].in[0]));
         if (tbl[i].in[0])
            chk($sformatf("v%0d_rdata", i), 64'(m0_readdata), 64'(32'hC0DE_0000 + 32'(i)));
         @(posedge iCLK);
         @(negedge iCLK);
      end

      // Reset pulsed while RD is granted with 4 reads in flight
      local_init_done = 1'b1; m0_read = 1'b1; m1_write = 1'b0;
      avl_ready = 1'b1; avl_rdata_valid = 1'b0;
      for (int i = 0; i < 5; i++) step();
      #1;
      chk("pre_rst_outstanding", 64'(outstanding), 64'(4));
      chk("pre_rst_read_req", 64'(avl_read_req), 64'(1));
      iRST_n = 1'b0;
      step();
      iRST_n = 1'b1;
      #1;
      chk("rst_read_req", 64'(avl_read_req), 64'(0));
      chk("rst_write_req", 64'(avl_write_req), 64'(0));
      chk("rst_burstbegin", 64'(avl_burstbegin), 64'(0));
      chk("rst_m0_wrn", 64'(m0_waitrequest_n), 64'(0));
      chk("rst_outstanding", 64'(outstanding), 64'(0));
      chk("rst_underflow", 64'(rd_underflow_err), 64'(0));

      // Outstanding limit: returns held back, reads stop at MAXOS
      sb_en = 1'b1; hold = 1'b1;
      nacc = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (last_rd_acc) begin
            nacc++;
            chk("bb_each_beat", 64'(last_bb), 64'(1));
         end
      end
      chk("accepts_to_limit", 64'(nacc), 64'(MAXOS));
      #1;
      chk("outstanding_full", 64'(outstanding), 64'(MAXOS));
      chk("read_req_blocked", 64'(avl_read_req), 64'(0));
      hold = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         chk("outstanding_bound", 64'(outstanding <= 4'(MAXOS)), 64'(1));
      end
      m0_read = 1'b0;
      for (int i = 0; i < 60 && (exp_q.size() > 0 || ret_q.size() > 0); i++) step();
      chk("drain1_empty", 64'(exp_q.size()), 64'(0));
      #1;
      chk("drain1_outstanding", 64'(outstanding), 64'(0));

      // Both masters saturating: RUN reads, one write, repeating
      m0_read = 1'b1; m1_write = 1'b1;
      rr = 0; nw = 0; prev_w = 1'b0;
      for (int i = 0; i < 220; i++) begin
         step();
         if (last_wr_acc) begin
            chk("rd_run_len", 64'(rr), 64'(RUN));
            chk("wr_single", 64'(prev_w), 64'(0));
            rr = 0;
            nw++;
         end
         if (last_rd_acc) rr++;
         prev_w = last_wr_acc;
      end
      chk("wr_not_starved", 64'(nw >= 11), 64'(1));
      m0_read = 1'b0; m1_write = 1'b0;
      for (int i = 0; i < 60 && (exp_q.size() > 0 || ret_q.size() > 0); i++) step();
      chk("drain2_empty", 64'(exp_q.size()), 64'(0));
      #1;
      chk("drain2_outstanding", 64'(outstanding), 64'(0));
      chk("final_underflow", 64'(rd_underflow_err), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
